seq_prog_ctrl: RTL and testbench

//  Program sequencer for the 4-register PUSH/ADD/MULT/SEND datapath. Holds a small

---
 rtl/seq_prog_ctrl_if.sv | 33 +++
 rtl/seq_prog_ctrl.sv | 114 +++++++++++
 tb/tb_seq_prog_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_prog_ctrl_if.sv
// Sequencer bus: board-side program load/control inputs, datapath busy
// feedback, and the instruction strobe/status outputs.
interface seq_prog_ctrl_if #(
    parameter int AW     = 4,
    parameter int INST_W = 8
);
    logic              ld_vld;
    logic [AW-1:0]     ld_addr;
    logic [INST_W-1:0] ld_data;
    logic [AW:0]       prog_len;
    logic              start;
    logic              abort;
    logic              step_mode;
    logic              step;
    logic              busy;
    logic              inst_vld;
    logic [INST_W-1:0] inst_wd;
    logic [AW-1:0]     pc;
    logic              running;
    logic              done;

    // Front end / datapath side
    modport master (
        output ld_vld, ld_addr, ld_data, prog_len, start, abort, step_mode, step, busy,
        input  inst_vld, inst_wd, pc, running, done
    );

    // Sequencer side
    modport slave (
        input  ld_vld, ld_addr, ld_data, prog_len, start, abort, step_mode, step, busy,
        output inst_vld, inst_wd, pc, running, done
    );
endinterface

// File: rtl/seq_prog_ctrl.sv
// Program sequencer: loadable instruction memory, issues each instruction as a
// one-cycle strobe, stalls on datapath busy, optional single-step mode.
module seq_prog_ctrl #(
    parameter int AW     = 4,
    parameter int INST_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_prog_ctrl_if.slave bus
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [INST_W-1:0] mem [DEPTH];
    logic [INST_W-1:0] rd_data;
    logic [INST_W-1:0] wd_q;
    logic [AW-1:0]     pc;
    logic [AW:0]       eff_len;
    logic [AW:0]       pc_next;
    logic              step_seen;
    logic              issue;
    logic              pc_clr;
    logic              pc_inc;
    logic              len_load;
    logic              ld_ok;

    assign pc_next = {1'b0, pc} + (AW + 1)'(1);
    assign ld_ok   = bus.ld_vld && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and control decode; abort overrides everything
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        len_load = 1'b0;
        if (bus.abort) begin
            state_nx = IDLE;
            pc_clr   = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start && bus.prog_len != '0) begin
                        state_nx = FETCH;
                        pc_clr   = 1'b1;
                        len_load = 1'b1;
                    end
                end
                FETCH: state_nx = ISSUE;
                ISSUE: begin
                    if (!bus.busy) begin
                        issue    = 1'b1;
                        state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.busy && (!bus.step_mode || bus.step || step_seen)) begin
                        if (pc_next == eff_len) begin
                            state_nx = DONE;
                        end else begin
                            pc_inc   = 1'b1;
                            state_nx = FETCH;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Program counter, run length, step latch and last-issued word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            eff_len   <= '0;
            step_seen <= 1'b0;
            wd_q      <= '0;
        end else begin
            if (pc_clr)      pc <= '0;
            else if (pc_inc) pc <= pc + AW'(1);
            if (len_load) eff_len <= (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
            // A step arriving while busy is remembered until WAIT is left
            step_seen <= (state == WAIT && state_nx == WAIT) && (step_seen || bus.step);
            if (issue) wd_q <= rd_data;
        end
    end

    // Instruction memory write port, only while not running
    always_ff @(posedge clk) begin
        if (ld_ok) mem[bus.ld_addr] <= bus.ld_data;
    end

    // Registered memory read during FETCH
    always_ff @(posedge clk) begin
        if (state == FETCH) rd_data <= mem[pc];
    end

    // The strobe is decoded from ISSUE so it appears two cycles after start;
    // inst_wd shows the fetched word during the strobe and the held copy otherwise.
    assign bus.inst_vld = issue;
    assign bus.inst_wd  = issue ? rd_data : wd_q;
    assign bus.pc       = pc;
    assign bus.running  = (state == FETCH) || (state == ISSUE) || (state == WAIT);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_seq_prog_ctrl.sv
// Directed bench for seq_prog_ctrl: run timing, busy stalls, single-step,
// abort, mid-run reset, zero/oversized program length, loads during a run.
module tb_seq_prog_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] prog [16];

    seq_prog_ctrl_if #(.AW(4), .INST_W(8)) bus ();

    seq_prog_ctrl #(.AW(4), .INST_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.ld_vld = 1'b1; bus.ld_addr = 4'(i); bus.ld_data = prog[i];
        end
        @(negedge clk);
        bus.ld_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ld_vld = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.prog_len = '0;
        bus.start = 0; bus.abort = 0; bus.step_mode = 0; bus.step = 0; bus.busy = 0;
        @(negedge clk); #1;
        total++; if (bus.inst_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", bus.inst_vld); end
        total++; if (bus.inst_wd !== 8'h00) begin bad++; $display("FAIL reset_wd: got %h want 00", bus.inst_wd); end
        total++; if (bus.pc !== 4'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", bus.pc); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", bus.running); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int k; int donec;
        bus.prog_len = 5'd9; bus.step_mode = 0; bus.busy = 0;
        @(negedge clk); bus.start = 1; #1;
        total++; if (bus.inst_vld !== 1'b0) begin bad++; $display("FAIL basic_c0_vld: got %b want 0", bus.inst_vld); end
        k = 0; donec = -1;
        for (int c = 1; c <= 60 && donec < 0; c++) begin
            @(negedge clk); bus.start = 0; #1;
            if (c == 1) begin
                total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL basic_running: got %b want 1", bus.running); end
            end
            if (bus.inst_vld === 1'b1) begin
                total++; if (c != 2 + 3 * k) begin bad++; $display("FAIL basic_time[%0d]: got cycle %0d want %0d", k, c, 2 + 3 * k); end
                if (k < 9) begin
                    total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                end
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        total++; if (k != 9) begin bad++; $display("FAIL basic_count: got %0d want 9", k); end
        total++; if (donec != 28) begin bad++; $display("FAIL basic_done_cycle: got %0d want 28", donec); end
        total++; if (bus.pc !== 4'd8) begin bad++; $display("FAIL basic_done_pc: got %0d want 8", bus.pc); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL basic_done_running: got %b want 0", bus.running); end
        total++; if (bus.inst_wd !== prog[8]) begin bad++; $display("FAIL basic_wd_hold: got %h want %h", bus.inst_wd, prog[8]); end
    endtask

    task automatic test_busy();
        int k; int donec; int busy_until; int exp; int vld_busy;
        @(negedge clk); bus.start = 1; #1;
        k = 0; donec = -1; busy_until = -1; exp = 2; vld_busy = 0;
        for (int c = 1; c <= 700 && donec < 0; c++) begin
            @(negedge clk); bus.start = 0; bus.busy = (c <= busy_until); #1;
            if (c == 1) begin
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL busy_restart_done: got %b want 0", bus.done); end
            end
            if (bus.inst_vld === 1'b1) begin
                if (bus.busy) vld_busy++;
                total++; if (c != exp) begin bad++; $display("FAIL busy_time[%0d]: got cycle %0d want %0d", k, c, exp); end
                if (k < 9) begin
                    total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL busy_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                    if (prog[k][7:6] == 2'b11) begin busy_until = c + 50; exp = c + 53; end
                    else exp = c + 3;
                end
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        bus.busy = 0;
        total++; if (k != 9) begin bad++; $display("FAIL busy_count: got %0d want 9", k); end
        total++; if (vld_busy != 0) begin bad++; $display("FAIL busy_vld_while_busy: got %0d want 0", vld_busy); end
        total++; if (donec != 228) begin bad++; $display("FAIL busy_done_cycle: got %0d want 228", donec); end
    endtask

    task automatic test_step();
        int k; int donec; int t; int exp; bit send;
        @(negedge clk); bus.start = 1; bus.step_mode = 1; #1;
        k = 0; donec = -1; t = -1000; exp = 2; send = 0;
        for (int c = 1; c <= 400 && donec < 0; c++) begin
            @(negedge clk);
            bus.start = 0;
            bus.busy  = send && (c >= t + 1) && (c <= t + 8);
            bus.step  = (c == t + (send ? 3 : 6));
            #1;
            if (bus.inst_vld === 1'b1) begin
                total++; if (c != exp) begin bad++; $display("FAIL step_time[%0d]: got cycle %0d want %0d", k, c, exp); end
                if (k < 9) begin
                    total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL step_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                    send = (prog[k][7:6] == 2'b11);
                end
                t = c;
                exp = send ? c + 11 : c + 8;
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        bus.step = 0; bus.busy = 0; bus.step_mode = 0;
        total++; if (k != 9) begin bad++; $display("FAIL step_count: got %0d want 9", k); end
        total++; if (donec != 85) begin bad++; $display("FAIL step_done_cycle: got %0d want 85", donec); end
    endtask

    task automatic test_abort();
        int k; int stray; int donec;
        k = 0;
        @(negedge clk); bus.start = 1; #1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); bus.start = 0;
            if (c == 12) bus.abort = 1;
            #1;
            if (bus.inst_vld === 1'b1) begin
                total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL abort_pre_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                k++;
            end
        end
        total++; if (k != 4) begin bad++; $display("FAIL abort_pre_count: got %0d want 4", k); end
        @(negedge clk); bus.abort = 0; #1;
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL abort_running: got %b want 0", bus.running); end
        total++; if (bus.pc !== 4'd0) begin bad++; $display("FAIL abort_pc: got %0d want 0", bus.pc); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", bus.done); end
        total++; if (bus.inst_wd !== prog[3]) begin bad++; $display("FAIL abort_wd_hold: got %h want %h", bus.inst_wd, prog[3]); end
        stray = 0;
        for (int c = 14; c <= 30; c++) begin
            @(negedge clk); bus.start = (c == 20); bus.abort = (c == 20); #1;
            if (bus.inst_vld === 1'b1) stray++;
            if (c == 21) begin
                total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL abort_wins_start: got running %b want 0", bus.running); end
            end
        end
        bus.start = 0; bus.abort = 0;
        total++; if (stray != 0) begin bad++; $display("FAIL abort_stray_pulses: got %0d want 0", stray); end
        @(negedge clk); bus.start = 1; #1;
        k = 0; donec = -1;
        for (int c = 1; c <= 60 && donec < 0; c++) begin
            @(negedge clk); bus.start = 0; #1;
            if (bus.inst_vld === 1'b1) begin
                if (k == 0) begin
                    total++; if (c != 2) begin bad++; $display("FAIL abort_rerun_time: got cycle %0d want 2", c); end
                    total++; if (bus.inst_wd !== prog[0]) begin bad++; $display("FAIL abort_rerun_data: got %h want %h", bus.inst_wd, prog[0]); end
                end
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        total++; if (k != 9) begin bad++; $display("FAIL abort_rerun_count: got %0d want 9", k); end
    endtask

    task automatic test_reset_mid();
        int k; int donec;
        @(negedge clk); bus.start = 1; #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); bus.start = 0; #1;
        end
        total++; if (bus.pc !== 4'd1) begin bad++; $display("FAIL rmid_pre_pc: got %0d want 1", bus.pc); end
        @(negedge clk); rst_n = 1'b0; #1;
        total++; if (bus.inst_vld !== 1'b0) begin bad++; $display("FAIL rmid_vld: got %b want 0", bus.inst_vld); end
        total++; if (bus.inst_wd !== 8'h00) begin bad++; $display("FAIL rmid_wd: got %h want 00", bus.inst_wd); end
        total++; if (bus.pc !== 4'd0) begin bad++; $display("FAIL rmid_pc: got %0d want 0", bus.pc); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL rmid_running: got %b want 0", bus.running); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", bus.done); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); bus.start = 1; #1;
        k = 0; donec = -1;
        for (int c = 1; c <= 60 && donec < 0; c++) begin
            @(negedge clk); bus.start = 0; #1;
            if (bus.inst_vld === 1'b1) begin
                total++; if (c != 2 + 3 * k) begin bad++; $display("FAIL rmid_time[%0d]: got cycle %0d want %0d", k, c, 2 + 3 * k); end
                if (k < 9) begin
                    total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL rmid_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                end
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        total++; if (k != 9 || donec != 28) begin bad++; $display("FAIL rmid_rerun: got count %0d done %0d want 9 28", k, donec); end
    endtask

    task automatic test_edge();
        int k; int donec; int stray;
        @(negedge clk); bus.abort = 1; #1;
        @(negedge clk); bus.abort = 0; #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL edge_abort_done: got %b want 0", bus.done); end
        @(negedge clk); bus.prog_len = 5'd0; bus.start = 1; #1;
        stray = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); bus.start = 0; #1;
            if (bus.inst_vld === 1'b1 || bus.running === 1'b1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL len0_ignored: got %0d active cycles want 0", stray); end
        bus.prog_len = 5'd9;
        @(negedge clk); bus.start = 1; #1;
        k = 0; donec = -1;
        for (int c = 1; c <= 60 && donec < 0; c++) begin
            @(negedge clk); bus.start = 0;
            bus.ld_vld = (c >= 3 && c <= 14); bus.ld_addr = 4'(c); bus.ld_data = 8'hFF;
            #1;
            if (bus.inst_vld === 1'b1) begin
                if (k < 9) begin
                    total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL ldrun_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                end
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        bus.ld_vld = 0;
        total++; if (k != 9) begin bad++; $display("FAIL ldrun_count: got %0d want 9", k); end
        bus.prog_len = 5'd31;
        @(negedge clk); bus.start = 1; #1;
        k = 0; donec = -1;
        for (int c = 1; c <= 120 && donec < 0; c++) begin
            @(negedge clk); bus.start = 0; #1;
            if (bus.inst_vld === 1'b1) begin
                total++; if (c != 2 + 3 * k) begin bad++; $display("FAIL len31_time[%0d]: got cycle %0d want %0d", k, c, 2 + 3 * k); end
                if (k < 16) begin
                    total++; if (bus.inst_wd !== prog[k]) begin bad++; $display("FAIL len31_data[%0d]: got %h want %h", k, bus.inst_wd, prog[k]); end
                end
                k++;
            end
            if (bus.done === 1'b1) donec = c;
        end
        total++; if (k != 16) begin bad++; $display("FAIL len31_count: got %0d want 16", k); end
        total++; if (donec != 49) begin bad++; $display("FAIL len31_done_cycle: got %0d want 49", donec); end
        total++; if (bus.pc !== 4'd15) begin bad++; $display("FAIL len31_pc: got %0d want 15", bus.pc); end
    endtask

    initial begin
        prog[0] = 8'b00000100; prog[1] = 8'b00000000; prog[2] = 8'b00010011;
        prog[3] = 8'b10000110; prog[4] = 8'b01100011; prog[5] = 8'b11000000;
        prog[6] = 8'b11010000; prog[7] = 8'b11100000; prog[8] = 8'b11110000;
        for (int i = 9; i < 16; i++) prog[i] = 8'h20 + 8'(i);
        test_reset();
        load_all();
        test_basic();
        test_busy();
        test_step();
        test_abort();
        test_reset_mid();
        test_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
